// File: rtl/ball_delivery.sv
// rtl/ball_delivery.sv - bowling-side ball source: throw, swing timing, deflection and strike pulse
// Optional feature macro: BALL_DELIVERY_OFFSIDE_EN (adds the side input, off-side deflection)
module ball_delivery #(
    parameter int STEP_DIV = 50000,
    parameter int X_PITCH  = 108,
    parameter int Y_START  = 10,
    parameter int Y_CREASE = 180,
    parameter int WINDOW   = 32,
    parameter int Y_STUMP  = 200,
    parameter int X_STUMP  = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bowl,
    input  logic       swing,
    input  logic       gameOver,
`ifdef BALL_DELIVERY_OFFSIDE_EN
    input  logic       side,
`endif
    output logic       throw,
    output logic       strike,
    output logic [8:0] pixelx,
    output logic [7:0] pixely,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, INCOMING, HIT, MISS, SETTLE} state_t;

    localparam int         CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [8:0] X_PITCH9 = 9'(X_PITCH);
    localparam logic [8:0] X_STUMP9 = 9'(X_STUMP);
    localparam logic [7:0] Y_START8 = 8'(Y_START);
    localparam logic [7:0] Y_CREASE8 = 8'(Y_CREASE);
    localparam logic [7:0] Y_STUMP8 = 8'(Y_STUMP);
    localparam int         WIN_LO   = Y_CREASE - WINDOW + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          bowl_q, swing_q, swing_used;
    logic [8:0]    tx;

    logic          tick, bowl_rise, swing_rise, in_window, counted;
    logic [4:0]    e;
    logic [8:0]    e3, tx_calc;
    logic [7:0]    y_inc;
    logic          running;

    // Edge detection, window test and deflection target for the current row
    always_comb begin
        tick       = (cnt == CNT_LAST);
        bowl_rise  = bowl & ~bowl_q;
        swing_rise = swing & ~swing_q;
        in_window  = (int'(pixely) >= WIN_LO) && (pixely <= Y_CREASE8);
        counted    = swing_rise && !swing_used && in_window;
        e          = 5'(Y_CREASE8 - pixely);
        e3         = {3'b000, e, 1'b0} + {4'b0000, e};
`ifdef BALL_DELIVERY_OFFSIDE_EN
        tx_calc    = side ? (X_PITCH9 + e3) : (X_PITCH9 - e3);
`else
        tx_calc    = X_PITCH9 - e3;
`endif
        y_inc      = pixely + 8'd1;
        running    = (state == INCOMING) || (state == HIT) || (state == MISS);
    end

    // Delivery FSM with registered throw/strike/busy and ball position
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bowl_q     <= 1'b0;
            swing_q    <= 1'b0;
            swing_used <= 1'b0;
            tx         <= X_PITCH9;
            throw      <= 1'b0;
            strike     <= 1'b0;
            busy       <= 1'b0;
            pixelx     <= X_PITCH9;
            pixely     <= Y_START8;
        end else begin
            bowl_q  <= bowl;
            swing_q <= swing;
            throw   <= 1'b0;
            strike  <= 1'b0;
            if (running) begin
                cnt <= tick ? '0 : cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (bowl_rise && !gameOver) begin
                        throw      <= 1'b1;
                        busy       <= 1'b1;
                        pixelx     <= X_PITCH9;
                        pixely     <= Y_START8;
                        swing_used <= 1'b0;
                        cnt        <= '0;
                        state      <= INCOMING;
                    end
                end
                INCOMING: begin
                    if (gameOver) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (counted) begin
                        // The swing is judged on the row before any step this cycle
                        swing_used <= 1'b1;
                        tx         <= tx_calc;
                        cnt        <= '0;
                        state      <= HIT;
                    end else if (tick) begin
                        pixely <= y_inc;
                        if (y_inc == Y_STUMP8) begin
                            pixelx <= X_STUMP9;
                        end
                        if (pixely == Y_CREASE8) begin
                            state <= MISS;
                        end
                    end
                end
                HIT: begin
                    if (gameOver) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (pixelx == tx) begin
                        strike <= 1'b1;
                        state  <= SETTLE;
                    end else if (tick) begin
                        pixelx <= (pixelx < tx) ? pixelx + 9'd1 : pixelx - 9'd1;
                    end
                end
                MISS: begin
                    if (gameOver) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (pixely == Y_STUMP8) begin
                        strike <= 1'b1;
                        state  <= SETTLE;
                    end else if (tick) begin
                        // Column jumps to the stumps together with the last row step,
                        // so the position is already settled when strike rises
                        pixely <= y_inc;
                        if (y_inc == Y_STUMP8) begin
                            pixelx <= X_STUMP9;
                        end
                    end
                end
                SETTLE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_delivery.sv
// tb/tb_ball_delivery.sv - self-checking bench for ball_delivery
module tb_ball_delivery;

    logic       clock = 1'b0;
    logic       reset, bowl, swing, gameOver;
`ifdef BALL_DELIVERY_OFFSIDE_EN
    logic       side;
`endif
    logic       throw, strike, busy;
    logic [8:0] pixelx;
    logic [7:0] pixely;

    int checks = 0;
    int errors = 0;

    ball_delivery #(
        .STEP_DIV(1), .X_PITCH(108), .Y_START(10), .Y_CREASE(180),
        .WINDOW(32), .Y_STUMP(200), .X_STUMP(5)
    ) dut (
        .clock(clock), .reset(reset), .bowl(bowl), .swing(swing), .gameOver(gameOver),
`ifdef BALL_DELIVERY_OFFSIDE_EN
        .side(side),
`endif
        .throw(throw), .strike(strike), .pixelx(pixelx), .pixely(pixely), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int r1;
        int r2;
        bit sd;
        int ex;
        int ey;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Reference: first swing landing in rows [Y_CREASE-WINDOW+1, Y_CREASE] decides the shot
    task automatic model(input int r1, input int r2, input bit sd,
                         output int ex, output int ey, output int ee);
        int r;
        r = -1;
        if (r1 >= 149 && r1 <= 180) r = r1;
        else if (r2 >= 149 && r2 <= 180) r = r2;
        if (r < 0) begin
            ex = 5; ey = 200; ee = -1;
        end else begin
            ee = 180 - r;
            ex = sd ? 108 + 3 * ee : 108 - 3 * ee;
            ey = r;
        end
    endtask

    task automatic deliver(input int r1, input int r2, input bit sd,
                           output int sx, output int sy, output int lat);
        bit fired1, fired2, got;
        int prevx, prevy, since;
        fired1 = 0; fired2 = 0; got = 0; since = 0;
        prevx = -1; prevy = -1; sx = -1; sy = -1; lat = -1;
        step();
        bowl = 1'b1;
`ifdef BALL_DELIVERY_OFFSIDE_EN
        side = sd;
`endif
        step();
        chk("throw_pulse", int'(throw), 1);
        chk("busy_at_throw", int'(busy), 1);
        chk("release_x", int'(pixelx), 108);
        chk("release_y", int'(pixely), 10);
        bowl = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (strike) begin
                got = 1;
                sx = int'(pixelx);
                sy = int'(pixely);
                lat = since;
                chk("throw_not_with_strike", int'(throw), 0);
                chk("busy_at_strike", int'(busy), 1);
                chk("stable_x_before_strike", sx, prevx);
                chk("stable_y_before_strike", sy, prevy);
                break;
            end
            swing = 1'b0;
            if (!fired1 && r1 >= 0 && int'(pixely) == r1) begin
                swing = 1'b1; fired1 = 1; since = 0;
            end else if (fired1 && !fired2 && r2 >= 0 && int'(pixely) == r2) begin
                swing = 1'b1; fired2 = 1; since = 0;
            end
            prevx = int'(pixelx);
            prevy = int'(pixely);
            step();
            since++;
        end
        swing = 1'b0;
        if (!got) begin
            chk("strike_timeout", 0, 1);
        end else begin
            step();
            chk("strike_one_cycle", int'(strike), 0);
            chk("busy_after_strike", int'(busy), 0);
            chk("held_x_after_strike", int'(pixelx), sx);
            chk("held_y_after_strike", int'(pixely), sy);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int sx, sy, lat, ex, ey, ee;
        deliver(v.r1, v.r2, v.sd, sx, sy, lat);
        model(v.r1, v.r2, v.sd, ex, ey, ee);
        chk({tag, "_x"}, sx, v.ex);
        chk({tag, "_y"}, sy, v.ey);
        chk({tag, "_model_x"}, sx, ex);
        if (ee >= 0) begin
            chk({tag, "_hit_latency"}, int'(lat >= 3 * ee && lat <= 3 * ee + 2), 1);
        end
    endtask

    initial begin
        vec_t tbl[$];
        int nstrike, nthrow, hx, hy;
        bit ok;

        reset = 1'b1; bowl = 1'b0; swing = 1'b0; gameOver = 1'b0;
`ifdef BALL_DELIVERY_OFFSIDE_EN
        side = 1'b0;
`endif
        step(); step();
        chk("reset_throw", int'(throw), 0);
        chk("reset_strike", int'(strike), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_x", int'(pixelx), 108);
        chk("reset_y", int'(pixely), 10);
        reset = 1'b0;
        step();

        tbl.push_back('{180, -1, 1'b0, 108, 180});
        tbl.push_back('{170, -1, 1'b0,  78, 170});
        tbl.push_back('{160, -1, 1'b0,  48, 160});
        tbl.push_back('{155, -1, 1'b0,  33, 155});
        tbl.push_back('{149, -1, 1'b0,  15, 149});
        tbl.push_back('{ -1, -1, 1'b0,   5, 200});
        tbl.push_back('{100, 175, 1'b0, 93, 175});
        tbl.push_back('{148, -1, 1'b0,   5, 200});
        tbl.push_back('{185, -1, 1'b0,   5, 200});
`ifdef BALL_DELIVERY_OFFSIDE_EN
        tbl.push_back('{170, -1, 1'b1, 138, 170});
`endif
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Randomized deliveries against the reference model
        for (int n = 0; n < 24; n++) begin
            vec_t v;
            int ee;
            v.r1 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(11, 198));
            v.r2 = (v.r1 >= 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(v.r1 + 1, 199)) : -1;
`ifdef BALL_DELIVERY_OFFSIDE_EN
            v.sd = 1'($urandom_range(0, 1));
`else
            v.sd = 1'b0;
`endif
            model(v.r1, v.r2, v.sd, v.ex, v.ey, ee);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of the run-in
        step();
        bowl = 1'b1;
        step();
        bowl = 1'b0;
        repeat (20) step();
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        chk("midreset_x", int'(pixelx), 108);
        chk("midreset_y", int'(pixely), 10);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_strike", int'(strike), 0);
        reset = 1'b0;
        nstrike = 0;
        repeat (10) begin
            step();
            if (strike || busy) nstrike++;
        end
        chk("after_reset_quiet", nstrike, 0);

        // gameOver raised while the ball is being deflected
        bowl = 1'b1;
        step();
        bowl = 1'b0;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            if (int'(pixely) == 150) begin ok = 1; break; end
            step();
        end
        chk("reach_row_150", int'(ok), 1);
        swing = 1'b1;
        step();
        swing = 1'b0;
        repeat (10) step();
        chk("hit_in_progress_busy", int'(busy), 1);
        gameOver = 1'b1;
        hx = int'(pixelx);
        hy = int'(pixely);
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_strike", int'(strike), 0);
        nstrike = 0;
        repeat (30) begin
            if (strike) nstrike++;
            step();
        end
        chk("abort_no_strike", nstrike, 0);
        chk("abort_y_held", int'(pixely), hy);
        chk("abort_x_near", int'(int'(pixelx) >= hx - 1 && int'(pixelx) <= hx + 1), 1);
        bowl = 1'b1;
        nthrow = 0;
        repeat (5) begin
            step();
            if (throw || busy) nthrow++;
        end
        chk("gameover_blocks_throw", nthrow, 0);
        gameOver = 1'b0;
        bowl = 1'b0;
        step();

        // Normal delivery still works after an aborted one
        run_vec('{165, -1, 1'b0, 63, 165}, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_delivery.md
# ball_delivery

Bowling-side source for the cricket game: on a bowl request it issues the `throw` pulse and animates the ball's `pixelx`/`pixely` position. It also times the batter's swing and deflects the ball to a landing column. When the ball comes to rest it issues a one-cycle `strike` pulse, so the downstream game analyzer samples the final position and scores it. It sits between the user buttons and the game analyzer, and also drives the VGA ball sprite.

## Interface
Parameters:
- `STEP_DIV`, 50000: clock cycles per ball pixel step (must be ≥1).
- `X_PITCH`, 108: ball column during run-in (must be ≥ 3*(WINDOW-1)).
- `Y_START`, 10: ball row at release.
- `Y_CREASE`, 180: batting row.
- `WINDOW`, 32: swing window depth in rows (power of two, ≤32).
- `Y_STUMP`, 200: row at which a missed ball hits the stumps.
- `X_STUMP`, 5: column reported for a bowled ball.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `bowl`  in  1  level; its rising edge requests a delivery.
- `swing`  in  1  level; its rising edge is a bat swing.
- `gameOver`  in  1  from the over counter; blocks and aborts deliveries.
- `throw`  out  1  one-cycle pulse at release.
- `strike`  out  1  one-cycle pulse when the ball is at rest.
- `pixelx`  out  9  ball column.
- `pixely`  out  8  ball row.
- `busy`  out  1  high from release until the end of the `strike` cycle.

## Operation
- Edge detection: `bowl` and `swing` are each registered once; a rise means current=1 and registered=0.
- FSM states: IDLE, INCOMING, HIT, MISS, SETTLE.
- Tick: a `STEP_DIV` counter runs in INCOMING, HIT and MISS. Entering any of those states clears it. One tick = one pixel step.

IDLE:
- On a bowl rise with `gameOver`=0:
  - `throw` pulses for one cycle.
  - `pixelx`←`X_PITCH`, `pixely`←`Y_START`.
  - The swing-used flag is cleared; go to INCOMING.
- Otherwise the last position is held.

INCOMING:
- Each tick, `pixely` increments by 1.
- A swing rise counts only while `Y_CREASE-WINDOW+1` ≤ `pixely` ≤ `Y_CREASE`, and only the first one (swing-used flag).
- On a counted swing:
  - e = `Y_CREASE`-`pixely` (5 bits).
  - Target column tx = `X_PITCH` − 3·e (9-bit unsigned).
  - Go to HIT.
- Swing rises outside the window are ignored and do not set the flag.
- If a tick would take `pixely` past `Y_CREASE` with no counted swing, go to MISS.

HIT:
- Each tick, `pixelx` steps by 1 toward tx; `pixely` is held.
- When `pixelx` = tx (including on entry), go to SETTLE.

MISS:
- Each tick, `pixely` increments.
- When `pixely` = `Y_STUMP`, `pixelx`←`X_STUMP` and go to SETTLE.

SETTLE:
- Lasts one cycle: `strike`=1, position unchanged.
- Then go to IDLE.

General rules:
- `gameOver`=1 in any non-IDLE state:
  - Go to IDLE on the next edge.
  - No `strike` is issued; position is held.
- A bowl rise while `busy` is ignored.

## Timing
- Reset values:
  - State IDLE; `throw`=0, `strike`=0, `busy`=0.
  - `pixelx`=`X_PITCH`, `pixely`=`Y_START`.
  - Tick counter 0, edge registers 0, swing-used 0.
- `throw` is high in the cycle following the edge that sampled the bowl rise; `busy` rises at the same time.
- First `pixely` increment comes `STEP_DIV` cycles after `throw`.
- A swing rise and a tick in the same cycle: the swing is judged against `pixely` before that cycle's update.
- `pixelx`/`pixely` are stable from at least one cycle before `strike` until the next `throw`.
- `strike` is never high in the same cycle as `throw`.

## Configuration
- `BALL_DELIVERY_OFFSIDE_EN` defined:
  - Adds input port `side` (1 bit), sampled together with the counted swing.
  - `side`=1 gives tx = `X_PITCH` + 3·e; `side`=0 gives tx = `X_PITCH` − 3·e.
- Undefined: no `side` port; tx = `X_PITCH` − 3·e always.

## Test plan
All scenarios use `STEP_DIV`=1 and default parameters unless stated.
- Reset asserted mid-INCOMING -> next cycle `pixelx`=108, `pixely`=10, `busy`=0, no `strike`.
- Bowl rise, swing rise when `pixely`=180 -> HIT ends immediately; `strike` with `pixelx`=108 (six).
- Swing rise at `pixely`=170 / 160 / 155 / 149 -> `strike` with `pixelx`=78 / 48 / 33 / 15 (four / two / one / zero), arriving e·3 cycles after entering HIT.
- No swing -> rows climb to 200; `strike` with `pixelx`=5, `pixely`=200 (out).
- Swing rise at `pixely`=100, then again at 175 -> the first is ignored, the second gives tx=93.
- `gameOver` raised mid-HIT -> IDLE next cycle with no `strike`; a later bowl rise gives no `throw` while `gameOver`=1.
- With `BALL_DELIVERY_OFFSIDE_EN`, `side`=1, swing at 170 -> `strike` with `pixelx`=138.
